// File: rtl/sub_seq_ctrl.sv
// Byte-serial subtractor: one 8-bit subtract stage walks the operands LSB first,
// chaining the borrow, then holds the result until the consumer acknowledges it.
module sub_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  ci,
    input  logic                  out_ack,
    output logic                  busy,
    output logic                  out_valid,
    output logic [8*NBYTES-1:0]   s,
    output logic                  co,
    output logic                  zero,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          borrow;

    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [8:0]    diff;
    logic [W-1:0]  s_next;
    logic          last;

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (cnt == CW'(k)) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8];
            end
        end
        // 9-bit difference: bit 8 is set exactly when a_byte < b_byte + borrow
        diff   = {1'b0, a_byte} - {1'b0, b_byte} - {8'd0, borrow};
        s_next = s;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (cnt == CW'(k)) s_next[8*k +: 8] = diff[7:0];
        end
        last = (cnt == CW'(NBYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            s      <= '0;
            co     <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= ci;
                        cnt    <= '0;
                        s      <= '0;
                        co     <= 1'b0;
                        zero   <= 1'b0;
                        ovf    <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    s      <= s_next;
                    borrow <= diff[8];
                    if (last) begin
                        co    <= diff[8];
                        zero  <= (s_next == '0);
                        ovf   <= (a_q[W-1] != b_q[W-1]) && (s_next[W-1] != a_q[W-1]);
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (NBYTES=4): vector table, random vectors
// and hand-written corner sequences, with a scoreboard of expected results.
module tb_sub_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ci = 1'b0;
    logic          out_ack = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [W-1:0]  s;
    logic          co;
    logic          zero;
    logic          ovf;

    sub_seq_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
        .out_ack(out_ack), .busy(busy), .out_valid(out_valid),
        .s(s), .co(co), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         zero;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        res_t         r;
    } vec_t;

    res_t sbq[$];
    res_t last_res;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full-width reference: {borrow, diff} = a - b - ci over 33 bits
    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
        logic [W:0] d;
        res_t r;
        d      = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, civ};
        r.s    = d[W-1:0];
        r.co   = d[W];
        r.zero = (d[W-1:0] == '0);
        r.ovf  = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
        return r;
    endfunction

    task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic civ, input logic hold);
        @(negedge clk);
        a = av; b = bv; ci = civ; start = 1'b1;
        sbq.push_back(model(av, bv, civ));
        @(posedge clk);
        #1;
        check("accept_busy", {63'd0, busy}, 64'd1);
        check("accept_clear", {31'd0, co, s}, 64'd0);
        if (!hold) start = 1'b0;
        a = $urandom; b = $urandom; ci = 1'($urandom);
    endtask

    task automatic wait_result(input string name);
        int   lat;
        res_t e;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(NB));
        if (sbq.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            last_res = e;
            check({name, "_s"}, 64'(s), 64'(e.s));
            check({name, "_flags"}, {61'd0, co, zero, ovf}, {61'd0, e.co, e.zero, e.ovf});
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check("ack_idle", {62'd0, busy, out_valid}, 64'd0);
        check("ack_retain", {31'd0, co, s}, {31'd0, last_res.co, last_res.s});
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{a:32'h00000001, b:32'h00000001, ci:1'b0, r:'{s:32'h00000000, co:1'b0, zero:1'b1, ovf:1'b0}};
        tbl[1] = '{a:32'h00000100, b:32'h00000001, ci:1'b0, r:'{s:32'h000000FF, co:1'b0, zero:1'b0, ovf:1'b0}};
        tbl[2] = '{a:32'h00000000, b:32'h00000000, ci:1'b1, r:'{s:32'hFFFFFFFF, co:1'b1, zero:1'b0, ovf:1'b0}};
        tbl[3] = '{a:32'h80000000, b:32'h00000001, ci:1'b0, r:'{s:32'h7FFFFFFF, co:1'b0, zero:1'b0, ovf:1'b1}};
        tbl[4] = '{a:32'h12345678, b:32'h12345678, ci:1'b1, r:'{s:32'hFFFFFFFF, co:1'b1, zero:1'b0, ovf:1'b0}};
        tbl[5] = '{a:32'h7FFFFFFF, b:32'hFFFFFFFF, ci:1'b0, r:'{s:32'h80000000, co:1'b1, zero:1'b0, ovf:1'b1}};

        #1;
        check("reset_outputs", {59'd0, busy, out_valid, co, zero, ovf}, 64'd0);
        check("reset_s", 64'(s), 64'd0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: expectations come from the table, not the model
        foreach (tbl[i]) begin
            drive_start(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0);
            void'(sbq.pop_back());
            sbq.push_back(tbl[i].r);
            wait_result($sformatf("vec%0d", i));
            do_ack();
        end

        for (int i = 0; i < 8; i++) begin
            drive_start($urandom, $urandom, 1'($urandom), 1'b0);
            wait_result($sformatf("rand%0d", i));
            do_ack();
        end

        // start held and operands churned during RUN; DONE held with no ack
        drive_start(32'hA5A50F0F, 32'h5A5AF0F1, 1'b1, 1'b1);
        wait_result("hold");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid_busy", {62'd0, out_valid, busy}, 64'd3);
            check("hold_s", 64'(s), 64'(last_res.s));
        end
        start = 1'b0;
        do_ack();

        // out_ack and start together in DONE: back to IDLE, start dropped
        drive_start(32'h00010000, 32'h00000001, 1'b0, 1'b0);
        wait_result("ackstart_first");
        @(negedge clk);
        out_ack = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check("ackstart_idle", {62'd0, busy, out_valid}, 64'd0);
        drive_start(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b0);
        wait_result("ackstart_second");
        do_ack();

        // asynchronous reset after the second RUN edge
        drive_start(32'hFFFFFFFF, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {59'd0, busy, out_valid, co, zero, ovf}, 64'd0);
        check("abort_s", 64'(s), 64'd0);
        void'(sbq.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(32'h00000000, 32'h00000001, 1'b0, 1'b0);
        wait_result("after_reset");
        do_ack();

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_seq_ctrl.md
SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the number of 8-bit bytes per operand (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request.
REQ-005 The block SHALL have port a, input, 8*NBYTES bits: minuend.
REQ-006 The block SHALL have port b, input, 8*NBYTES bits: subtrahend.
REQ-007 The block SHALL have port ci, input, 1 bit: borrow-in to the least significant byte.
REQ-008 The block SHALL have port out_ack, input, 1 bit: consumer acknowledge of the result.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port s, output, 8*NBYTES bits: difference.
REQ-012 The block SHALL have port co, output, 1 bit: borrow-out of the most significant byte.
REQ-013 The block SHALL have port zero, output, 1 bit: high when s is all zeros.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL use exactly one 8-bit subtract stage, computing s8 = a8 - b8 - ci8 mod 256 with co8 = 1 iff a8 < b8 + ci8, time-shared across all bytes.
REQ-016 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch a, b and ci into internal registers, clear the byte counter, and move the state to RUN.
REQ-018 In RUN, each rising edge SHALL process byte k (k = 0 first, LSB first), write s[8k+7:8k], and pass that byte's borrow-out as the next byte's borrow-in.
REQ-019 The borrow-in for byte 0 SHALL be the latched ci.
REQ-020 After the edge that processes byte NBYTES-1, the state SHALL be DONE and co SHALL equal the final borrow.
REQ-021 Latency: if start is accepted at edge T, out_valid SHALL rise after edge T+NBYTES (4 cycles at the default).
REQ-022 No throughput overlap SHALL exist: a new start is accepted only in IDLE.
REQ-023 start SHALL be ignored in RUN and DONE, with no effect on the latched operands.
REQ-024 a, b and ci SHALL be don't-care except on the accepting edge; changes during RUN SHALL NOT affect the result.
REQ-025 In DONE, out_valid SHALL be 1, and s, co, zero and ovf SHALL be stable.
REQ-026 DONE SHALL be held indefinitely until out_ack=1 at an edge, which moves the state to IDLE.
REQ-027 out_ack SHALL be ignored outside DONE.
REQ-028 If out_ack and start are both 1 in DONE, the block SHALL go to IDLE and drop the start; a new start must be presented in IDLE.
REQ-029 After the acknowledge, s, co, zero and ovf SHALL retain their last values until the next accepted start.
REQ-030 On an accepted start, s, co, zero and ovf SHALL clear to 0.
REQ-031 During RUN, s SHALL show partial results; consumers use s only while out_valid=1.
REQ-032 zero SHALL be computed in DONE from the full s, independent of co.
REQ-033 ovf SHALL be (a_msb != b_msb) && (s_msb != a_msb), using the latched operands and the final s.
REQ-034 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-035 The byte counter SHALL be ceil(log2(NBYTES)) bits wide and SHALL NOT wrap during RUN; the exit condition is counter == NBYTES-1.

Reset
REQ-036 rst_n=0 SHALL force the following immediately, without waiting for clk: state IDLE, counter 0, latched operands 0, busy=0, out_valid=0, s=0, co=0, zero=0, ovf=0.
REQ-037 Reset asserted during RUN or DONE SHALL abort the operation with no result produced.
REQ-038 The first start accepted after rst_n returns to 1 SHALL behave as from power-up.
REQ-039 Reset deassertion SHALL be synchronous to clk from the block's point of view; inputs are don't-care while rst_n=0.

Verification (NBYTES=4)
REQ-040 a=0x00000001, b=0x00000001, ci=0, start pulse -> after 4 edges: out_valid=1, s=0x00000000, co=0, zero=1, ovf=0.
REQ-041 a=0x00000100, b=0x00000001, ci=0 -> s=0x000000FF, co=0, zero=0; the borrow crosses from byte 0 to byte 1.
REQ-042 a=0x00000000, b=0x00000000, ci=1 -> s=0xFFFFFFFF, co=1, ovf=0; then a=0x80000000, b=0x00000001, ci=0 -> s=0x7FFFFFFF, co=0, ovf=1.
REQ-043 Start accepted, then start held high with a and b changed during RUN, and out_ack held 0 for 10 cycles -> result matches the first operands, out_valid stays 1 and busy stays 1 throughout.
REQ-044 out_ack=1 and start=1 in the same DONE cycle -> IDLE next cycle with no new operation; start on the following cycle is accepted and out_valid returns 4 edges later.
REQ-045 rst_n pulsed low after the 2nd RUN edge -> all outputs 0 at once without a clk edge; a new start after release gives the correct full result.
